// File: rtl/fifo_pkg.sv
// Shared definitions for the programmable FIFO: read-mode constants and
// the occupancy counter width helper.
package fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  // Counter must represent 0..depth inclusive, hence one bit above the pointer width.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: one synchronous write port and one read port that is
// registered in standard mode and combinational in first-word-fall-through mode.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int MODE  = FIFO_STD,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  generate
    if (MODE == FIFO_FWFT) begin : g_fwft
      // re carries "FIFO not empty": the head is shown only while it is real data.
      assign rdata = (re && !rst) ? mem_q[raddr] : {WIDTH{1'b0}};
    end else begin : g_std
      logic [WIDTH-1:0] rdata_q;

      // Registered read of the head word; holds its value between reads.
      always_ff @(posedge clk) begin
        if (rst) begin
          rdata_q <= {WIDTH{1'b0}};
        end else if (re) begin
          rdata_q <= mem_q[raddr];
        end
      end

      assign rdata = rdata_q;
    end
  endgenerate

endmodule

// File: rtl/fifo_prog.sv
// Programmable synchronous FIFO: pointers, occupancy counter, threshold flags
// and single-cycle status pulses around the fifo_mem storage block.
module fifo_prog
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_THRESH  = FIFO_DEPTH - 1,
  parameter int AE_THRESH  = 1,
  parameter int FWFT       = FIFO_STD
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [FIFO_WIDTH-1:0]            data_in,
  input  logic                             wr_en,
  input  logic                             rd_en,
  output logic [FIFO_WIDTH-1:0]            data_out,
  output logic                             rd_valid,
  output logic                             wr_ack,
  output logic                             overflow,
  output logic                             underflow,
  output logic                             full,
  output logic                             empty,
  output logic                             almostfull,
  output logic                             almostempty,
  output logic [cnt_width(FIFO_DEPTH)-1:0] count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = cnt_width(FIFO_DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_ack_q, wr_ack_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          rd_valid_q, rd_valid_d;
  logic          rd_accept_s, wr_accept_s;
  logic          full_s, empty_s;

  assign full_s  = (count_q == CW'(FIFO_DEPTH));
  assign empty_s = (count_q == {CW{1'b0}});

  // A pop in the same cycle frees the slot, so a full FIFO still takes the write.
  assign rd_accept_s = rd_en && !empty_s;
  assign wr_accept_s = wr_en && (!full_s || rd_accept_s);

  // Next-state for pointers, occupancy and status pulses.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    wr_ack_d    = wr_accept_s;
    overflow_d  = wr_en && !wr_accept_s;
    underflow_d = rd_en && !rd_accept_s;
    rd_valid_d  = rd_accept_s;
    if (wr_accept_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_accept_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_accept_s, rd_accept_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      count_q     <= {CW{1'b0}};
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wr_ack_q    <= wr_ack_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  fifo_mem #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .MODE  (FWFT)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_accept_s),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .re    ((FWFT == FIFO_FWFT) ? !empty_s : rd_accept_s),
    .raddr (rd_ptr_q),
    .rdata (data_out)
  );

  assign rd_valid    = (FWFT == FIFO_FWFT) ? !empty_s : rd_valid_q;
  assign wr_ack      = wr_ack_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;
  assign full        = full_s;
  assign empty       = empty_s;
  assign almostfull  = (count_q >= CW'(AF_THRESH));
  assign almostempty = (count_q <= CW'(AE_THRESH));
  assign count       = count_q;

endmodule

// File: tb/tb_fifo_prog.sv
// Scoreboard bench: a standard-mode FIFO (8 deep) and a FWFT FIFO (16 deep,
// AF=12, AE=3) share one random/directed stimulus stream and a queue-based model.
module tb_fifo_prog;

  typedef logic [15:0] word_t;
  typedef struct {
    bit    rs;
    int    cnt;
    bit    wr_ack, ovf, udf, full, empty, af, ae, valid, rd_acc;
    word_t word, head;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1, wr_en = 1'b0, rd_en = 1'b0;
  word_t data_in = 16'h0000;

  word_t       s_dout, f_dout;
  logic        s_valid, s_ack, s_ovf, s_udf, s_full, s_empty, s_af, s_ae;
  logic        f_valid, f_ack, f_ovf, f_udf, f_full, f_empty, f_af, f_ae;
  logic [3:0]  s_count;
  logic [4:0]  f_count;

  word_t q_s[$], q_f[$], rdq_s[$];
  exp_t  exq_s[$], exq_f[$];
  int    checks = 0, errors = 0;
  word_t last_s = 16'h0000;

  always #5 clk = ~clk;

  fifo_prog u_std (
    .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
    .data_out(s_dout), .rd_valid(s_valid), .wr_ack(s_ack), .overflow(s_ovf),
    .underflow(s_udf), .full(s_full), .empty(s_empty), .almostfull(s_af),
    .almostempty(s_ae), .count(s_count)
  );

  fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(16), .AF_THRESH(12), .AE_THRESH(3), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
    .data_out(f_dout), .rd_valid(f_valid), .wr_ack(f_ack), .overflow(f_ovf),
    .underflow(f_udf), .full(f_full), .empty(f_empty), .almostfull(f_af),
    .almostempty(f_ae), .count(f_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: FIFO as a plain queue; expected state after the coming clock edge.
  task automatic model(ref word_t q[$], input int depth, input int afth, input int aeth,
                       input bit fw, input bit r, input bit w, input bit rd, input word_t d,
                       output exp_t e);
    int n;
    e = '{default: 0};
    e.rs = r;
    if (r) begin
      q.delete();
    end else begin
      n = q.size();
      e.rd_acc = rd && (n > 0);
      e.wr_ack = w && ((n < depth) || e.rd_acc);
      e.ovf    = w && !e.wr_ack;
      e.udf    = rd && (n == 0);
      if (e.rd_acc) e.word = q.pop_front();
      if (e.wr_ack) q.push_back(d);
    end
    n       = q.size();
    e.cnt   = n;
    e.full  = (n == depth);
    e.empty = (n == 0);
    e.af    = (n >= afth);
    e.ae    = (n <= aeth);
    e.valid = fw ? (n > 0) : e.rd_acc;
    e.head  = (n > 0) ? q[0] : 16'h0000;
  endtask

  task automatic drive(input bit r, input bit w, input bit rd, input word_t d);
    exp_t es, ef;
    @(negedge clk);
    rst = r; wr_en = w; rd_en = rd; data_in = d;
    model(q_s, 8, 7, 1, 1'b0, r, w, rd, d, es);
    exq_s.push_back(es);
    if (r) rdq_s.delete();
    if (es.rd_acc) rdq_s.push_back(es.word);
    model(q_f, 16, 12, 3, 1'b1, r, w, rd, d, ef);
    exq_f.push_back(ef);
  endtask

  // Monitor: compares each DUT against the expectation queued for this edge.
  always @(posedge clk) begin : mon
    exp_t  e;
    word_t w;
    #1;
    if (exq_s.size() > 0) begin
      e = exq_s.pop_front();
      chk("s_count", 32'(s_count), 32'(e.cnt));
      chk("s_flags", {28'd0, s_full, s_empty, s_af, s_ae}, {28'd0, e.full, e.empty, e.af, e.ae});
      chk("s_pulses", {29'd0, s_ack, s_ovf, s_udf}, {29'd0, e.wr_ack, e.ovf, e.udf});
      chk("s_rd_valid", 32'(s_valid), 32'(e.valid));
      if (s_valid === 1'b1) begin
        if (rdq_s.size() == 0) begin
          chk("s_unexpected_read", 32'(1), 32'(0));
        end else begin
          w = rdq_s.pop_front();
          chk("s_data", 32'(s_dout), 32'(w));
          last_s = w;
        end
      end else if (e.rs) begin
        chk("s_data_reset", 32'(s_dout), 32'(0));
        last_s = 16'h0000;
      end else begin
        chk("s_data_hold", 32'(s_dout), 32'(last_s));
      end
    end
    if (exq_f.size() > 0) begin
      e = exq_f.pop_front();
      chk("f_count", 32'(f_count), 32'(e.cnt));
      chk("f_flags", {28'd0, f_full, f_empty, f_af, f_ae}, {28'd0, e.full, e.empty, e.af, e.ae});
      chk("f_pulses", {29'd0, f_ack, f_ovf, f_udf}, {29'd0, e.wr_ack, e.ovf, e.udf});
      chk("f_rd_valid", 32'(f_valid), 32'(e.valid));
      if (e.valid) chk("f_head", 32'(f_dout), 32'(e.head));
      else if (e.rs) chk("f_data_reset", 32'(f_dout), 32'(0));
    end
  end

  initial begin
    int wp, rp;
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    drive(1'b1, 1'b1, 1'b1, 16'hDEAD);
    // Fill past full, then drain past empty.
    for (int i = 1; i <= 9; i++) drive(1'b0, 1'b1, 1'b0, word_t'(i));
    for (int i = 0; i < 9; i++) drive(1'b0, 1'b0, 1'b1, 16'h0000);
    drive(1'b0, 1'b0, 1'b1, 16'h0000);
    // Simultaneous read/write while full.
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 1'b0, word_t'(16'h0011 + i));
    drive(1'b0, 1'b1, 1'b1, 16'h00AA);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 1'b1, 16'h0000);
    // Simultaneous read/write while empty.
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    drive(1'b0, 1'b1, 1'b1, 16'h0055);
    drive(1'b0, 1'b0, 1'b1, 16'h0000);
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    // FWFT visibility and threshold crossings.
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    drive(1'b0, 1'b1, 1'b0, 16'h1234);
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 14; i++) drive(1'b0, 1'b1, 1'b0, word_t'($urandom));
    for (int i = 0; i < 16; i++) drive(1'b0, 1'b0, 1'b1, 16'h0000);
    // Random traffic with alternating bias to hit both full and empty.
    for (int i = 0; i < 1000; i++) begin
      wp = ((i / 120) % 2 == 0) ? 70 : 35;
      rp = 100 - wp;
      drive(1'b0, $urandom_range(99) < wp, $urandom_range(99) < rp, word_t'($urandom));
    end
    for (int k = 0; k < 64 && q_s.size() != 5; k++)
      drive(1'b0, q_s.size() < 5, q_s.size() > 5, word_t'($urandom));
    drive(1'b1, 1'b1, 1'b1, word_t'($urandom));
    for (int i = 0; i < 1000; i++) begin
      wp = ((i / 90) % 2 == 0) ? 65 : 40;
      rp = 100 - wp;
      drive(1'b0, $urandom_range(99) < wp, $urandom_range(99) < rp, word_t'($urandom));
    end
    for (int i = 0; i < 18; i++) drive(1'b0, 1'b0, 1'b1, 16'h0000);
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    @(posedge clk);
    #3;
    chk("s_reads_outstanding", 32'(rdq_s.size()), 32'(0));
    chk("s_expect_outstanding", 32'(exq_s.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_prog.md
FIFO_PROG -- requirements
Module: fifo_prog

Interface
REQ-001 Parameter FIFO_WIDTH, default 16, data word width in bits (1..64).
REQ-002 Parameter FIFO_DEPTH, default 8, number of entries; power of two, 4..1024.
REQ-003 Parameter AF_THRESH, default FIFO_DEPTH-1, occupancy at or above which almostfull asserts (1..FIFO_DEPTH-1).
REQ-004 Parameter AE_THRESH, default 1, occupancy at or below which almostempty asserts (1..FIFO_DEPTH-1, < AF_THRESH).
REQ-005 Parameter FWFT, default 0, 0 = standard read mode, 1 = first-word-fall-through mode.
REQ-006 clk  input  1  single clock, all logic on rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 data_in  input  FIFO_WIDTH  write data.
REQ-009 wr_en  input  1  write request.
REQ-010 rd_en  input  1  read request (FWFT: pop acknowledge).
REQ-011 data_out  output  FIFO_WIDTH  read data.
REQ-012 rd_valid  output  1  data_out holds valid read data.
REQ-013 wr_ack  output  1  previous-cycle write accepted.
REQ-014 overflow  output  1  previous-cycle write rejected because full.
REQ-015 underflow  output  1  previous-cycle read rejected because empty.
REQ-016 full, empty, almostfull, almostempty  output  1 each  occupancy flags.
REQ-017 count  output  $clog2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH.

Function
REQ-018 Write accepted = wr_en && (!full || rd_accept); read accepted (rd_accept) = rd_en && !empty.
REQ-019 Full with wr_en && rd_en: read and write both accepted, count unchanged.
REQ-020 Empty with wr_en && rd_en: write only accepted, underflow asserted next cycle, count +1.
REQ-021 count: registered, +1 on write-only, -1 on read-only, unchanged on both or neither; never exceeds FIFO_DEPTH nor goes below 0.
REQ-022 Flags combinational from count register: full = (count==FIFO_DEPTH), empty = (count==0), almostfull = (count>=AF_THRESH), almostempty = (count<=AE_THRESH).
REQ-023 Write/read pointers $clog2(FIFO_DEPTH) bits, increment on accept, wrap FIFO_DEPTH-1 -> 0.
REQ-024 wr_ack, overflow, underflow: registered single-cycle pulses, one cycle after the qualifying request; overflow = wr_en && !write accepted.
REQ-025 FWFT=0: accepted read registers head word on data_out with 1-cycle latency, rd_valid pulses that cycle; data_out holds last value otherwise.
REQ-026 FWFT=1: data_out presents head word whenever count>0, rd_valid = !empty; rd_en pops, next word visible the following cycle; a write into empty FIFO is visible on data_out one cycle after the write.
REQ-027 Reads return words in exact write order; no word lost or duplicated across pointer wrap.

Reset
REQ-028 rst sampled on clk edge: pointers, count, wr_ack, overflow, underflow, rd_valid -> 0; data_out -> 0; hence empty=1, almostempty=1, full=0, almostfull=0.
REQ-029 rst overrides simultaneous wr_en/rd_en; mid-operation reset discards all content, memory array contents not cleared.

Structure
REQ-030 Shared package fifo_pkg holds count-width function and the FWFT mode constants (FIFO_STD, FIFO_FWFT).
REQ-031 Storage in sub-module fifo_mem: FIFO_DEPTH x FIFO_WIDTH array, one synchronous write port, one read port (registered read for FWFT=0, combinational for FWFT=1).
REQ-032 Pointer, count, flag and status logic resides in fifo_prog.

Verification
REQ-033 Defaults, FWFT=0: rst then 8 writes 0x0001..0x0008 -> wr_ack x8, full=1 after 8th, almostfull=1 after 7th; 9th write -> overflow=1 one cycle later, count=8.
REQ-034 From full, 8 reads -> data_out 0x0001..0x0008 in order, each 1 cycle after rd_en with rd_valid; 9th read -> underflow=1, empty=1.
REQ-035 Full, wr_en=rd_en=1 with data_in 0x00AA -> count stays 8, no overflow, 0x00AA read out last after draining.
REQ-036 Empty, wr_en=rd_en=1 data_in 0x0055 -> underflow=1, count=1, next read returns 0x0055.
REQ-037 FWFT=1, DEPTH=16, AF=12, AE=3: write 0x1234 into empty -> data_out=0x1234, rd_valid=1 next cycle without rd_en; almostfull at count 12, almostempty clears at count 4.
REQ-038 Random 2000-cycle wr_en/rd_en traffic with wrap, rst asserted at cycle 1000 with count=5 -> count=0, empty=1 next cycle, scoreboard flushed, order preserved throughout.
